// File: rtl/tcdm_bank_arbiter_pkg.sv
// Shared types and helpers for the TCDM bank arbiter: index width function
// and the {valid, idx} response-pipeline stage record.
package tcdm_arb_pkg;

  // Widest master index a response stage can carry (up to 256 masters).
  localparam int unsigned MaxIdxWidth = 8;

  function automatic int unsigned idx_width(input int unsigned num_in);
    int unsigned n;
    n = (num_in > 2) ? num_in : 2;
    return $clog2(n);
  endfunction

  typedef struct packed {
    logic                   valid;
    logic [MaxIdxWidth-1:0] idx;
  } resp_stage_t;

endpackage

// File: rtl/tcdm_bank_arbiter_rr_sel.sv
// Combinational round-robin pick: first set request scanning cyclically
// upward from the pointer.
module rr_sel
  import tcdm_arb_pkg::*;
#(
  parameter int unsigned NumIn    = 8,
  parameter int unsigned IdxWidth = 3
) (
  input  logic [NumIn-1:0]    req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                any_o
);

  logic [2*NumIn-1:0] dbl;
  logic [NumIn-1:0]   rot;
  int                 off;
  int                 sum;

  always_comb begin
    // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
    dbl = {req_i, req_i} >> ptr_i;
    rot = dbl[NumIn-1:0];
    off = 0;
    for (int k = NumIn - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = k;
      end
    end
    sum = int'(ptr_i) + off;
    if (sum >= int'(NumIn)) begin
      sum = sum - int'(NumIn);
    end
    idx_o = IdxWidth'(sum);
    any_o = |req_i;
  end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one TCDM bank between NumIn masters, with a
// fixed-latency response pipeline. Optional conflict counter: TCDM_BANK_ARB_PERF_EN.
module tcdm_bank_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter int unsigned NumIn         = 8,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32,
  parameter int unsigned RespLat       = 1,
  parameter logic        WriteRespOn   = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
`ifdef TCDM_BANK_ARB_PERF_EN
  input  logic                          clr_cnt_i,
  output logic [31:0]                   conflict_cnt_o,
`endif
  input  logic [NumIn-1:0]              req_i,
  input  logic [NumIn-1:0]              wen_i,
  input  logic [NumIn*ReqDataWidth-1:0] data_i,
  output logic [NumIn-1:0]              gnt_o,
  output logic [NumIn-1:0]              vld_o,
  output logic [RespDataWidth-1:0]      rdata_o,
  output logic                          req_o,
  input  logic                          gnt_i,
  output logic                          wen_o,
  output logic [ReqDataWidth-1:0]       data_o,
  input  logic [RespDataWidth-1:0]      rdata_i
);

  localparam int unsigned IdxWidth = idx_width(NumIn);

  logic [IdxWidth-1:0] rr_q, rr_d;
  logic [IdxWidth-1:0] winner;
  logic                any;
  logic                fire;
  resp_stage_t         stage0_d;
  resp_stage_t         pipe_q [RespLat];

  rr_sel #(
    .NumIn   (NumIn),
    .IdxWidth(IdxWidth)
  ) u_rr_sel (
    .req_i(req_i),
    .ptr_i(rr_q),
    .idx_o(winner),
    .any_o(any)
  );

  assign req_o   = any;
  assign fire    = gnt_i & any;
  assign rdata_o = rdata_i;

  always_comb begin
    wen_o  = 1'b0;
    data_o = '0;
    for (int i = 0; i < int'(NumIn); i++) begin
      if (any && (winner == IdxWidth'(i))) begin
        wen_o  = wen_i[i];
        data_o = data_i[i*ReqDataWidth +: ReqDataWidth];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < int'(NumIn); gi++) begin : g_port
      assign gnt_o[gi] = fire && (winner == IdxWidth'(gi));
      assign vld_o[gi] = pipe_q[RespLat-1].valid &&
                         (pipe_q[RespLat-1].idx == MaxIdxWidth'(gi));
    end
  endgenerate

  always_comb begin
    rr_d = rr_q;
    if (fire) begin
      rr_d = (int'(winner) + 1 == int'(NumIn)) ? '0 : winner + IdxWidth'(1);
    end
    stage0_d.valid = fire & (~wen_o | WriteRespOn);
    stage0_d.idx   = MaxIdxWidth'(winner);
  end

  // The pipeline never stalls: a response is owed RespLat cycles after its grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
      for (int s = 0; s < int'(RespLat); s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      rr_q      <= rr_d;
      pipe_q[0] <= stage0_d;
      for (int s = 1; s < int'(RespLat); s++) begin
        pipe_q[s] <= pipe_q[s-1];
      end
    end
  end

`ifdef TCDM_BANK_ARB_PERF_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (clr_cnt_i) begin
      conflict_cnt_d = '0;
    end else if (((req_i & ~gnt_o) != '0) && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule
